// File: rtl/ble_telemetry_tx_pkg.sv
// ble_pkg: shared definitions for the BLE telemetry transmitter.
//   BLE_SYNC_BYTE  - first byte of every frame
//   BLE_FRAME_LEN  - bytes per frame (8 with BLE_TELEMETRY_CHECKSUM_EN, else 7)
//   ble_angle_t    - 9-bit signed attitude angle
//   frame-level and serializer-level state enums
//   ble_sext16     - sign-extends an angle to its 16-bit on-wire form
// Configuration macro: BLE_TELEMETRY_CHECKSUM_EN
package ble_pkg;

   localparam logic [7:0] BLE_SYNC_BYTE = 8'hA5;

`ifdef BLE_TELEMETRY_CHECKSUM_EN
   localparam int unsigned BLE_FRAME_LEN = 8;
`else
   localparam int unsigned BLE_FRAME_LEN = 7;
`endif

   typedef logic signed [8:0] ble_angle_t;

   typedef enum logic [1:0] {
      FRM_IDLE,
      FRM_LOAD,
      FRM_WAIT
   } ble_frame_state_t;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_START,
      SER_DATA,
      SER_STOP
   } ble_ser_state_t;

   function automatic logic [15:0] ble_sext16(input ble_angle_t a);
      return {{7{a[8]}}, a};
   endfunction

endpackage

// File: rtl/ble_telemetry_tx_uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer, LSB first, DIV clocks per bit.
//   clock     - system clock, rising edge
//   reset_n   - asynchronous active-low reset (tx forced high)
//   load      - start a byte; data is captured on the same edge.
//               Accepted in IDLE or in the final cycle of the stop bit,
//               so consecutive bytes have no idle bits between them.
//   data      - byte to send
//   tx        - registered serial output, idles high
//   ready     - serializer idle
//   byte_done - one-cycle pulse in the final cycle of the stop bit
module uart_tx_byte
   import ble_pkg::*;
#(
   parameter int unsigned DIV = 868
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready,
   output logic       byte_done
);

   localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   ble_ser_state_t state;
   logic [CW-1:0]  cnt;
   logic [2:0]     bit_idx;
   logic [7:0]     data_q;
   logic           bit_end;

   assign bit_end   = (cnt == CNT_LAST);
   assign ready     = (state == SER_IDLE);
   assign byte_done = (state == SER_STOP) && bit_end;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= SER_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         data_q  <= '0;
         tx      <= 1'b1;
      end else begin
         case (state)
            SER_IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (load) begin
                  state  <= SER_START;
                  data_q <= data;
                  tx     <= 1'b0;
               end
            end

            SER_START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= SER_DATA;
                  tx      <= data_q[0];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            SER_DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= SER_STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= data_q[bit_idx + 3'd1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            SER_STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  // Chaining straight into the next start bit keeps bytes
                  // back-to-back with bit boundaries on exact DIV multiples.
                  if (load) begin
                     state  <= SER_START;
                     data_q <= data;
                     tx     <= 1'b0;
                  end else begin
                     state <= SER_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               state <= SER_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/ble_telemetry_tx.sv
// ble_telemetry_tx: framed UART transmitter streaming roll/pitch/yaw to
// the BLE module.  Frame: A5, roll, pitch, yaw (each sign-extended to
// 16 bits, high byte first), then an optional 8-bit sum of the six
// payload bytes.
//   CLK_HZ, BAUD - bit period DIV = CLK_HZ/BAUD (truncated)
//   clock        - system clock, rising edge
//   reset_n      - asynchronous active-low reset; abandons any frame
//   send         - frame request, accepted when busy is low
//   roll/pitch/yaw - 9-bit signed angles, captured on the accept edge
//   busy         - high from the cycle after accept until frame end
//   done         - one-cycle pulse after the last stop bit
//   tx           - serial line to the BLE module, idles high
// Configuration macro: BLE_TELEMETRY_CHECKSUM_EN (adds the checksum byte)
module ble_telemetry_tx
   import ble_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 115_200
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              send,
   input  logic signed [8:0] roll,
   input  logic signed [8:0] pitch,
   input  logic signed [8:0] yaw,
   output logic              busy,
   output logic              done,
   output logic              tx
);

   localparam int unsigned DIV      = CLK_HZ / BAUD;
   localparam logic [2:0]  LAST_IDX = 3'(BLE_FRAME_LEN - 1);

   ble_frame_state_t fstate;
   logic [2:0]       idx;
   logic [2:0]       nxt_idx;
   logic [47:0]      shadow;
   logic             accept;
   logic             ser_load;
   logic             ser_ready;
   logic             ser_byte_done;
   logic [7:0]       ser_data;
`ifdef BLE_TELEMETRY_CHECKSUM_EN
   logic [7:0]       csum;
`endif

   assign accept  = send && !busy && ser_ready;
   assign nxt_idx = (fstate == FRM_IDLE) ? 3'd0 : idx + 3'd1;

   // The serializer load is combinational so the start bit leaves on the
   // accept edge itself and each following byte on the previous byte's
   // final stop-bit edge; the frame FSM tracks which byte is in flight.
   assign ser_load = accept ||
                     ((fstate == FRM_WAIT) && ser_byte_done && (idx != LAST_IDX));

   always_comb begin
      ser_data = BLE_SYNC_BYTE;
      case (nxt_idx)
         3'd1:    ser_data = shadow[47:40];
         3'd2:    ser_data = shadow[39:32];
         3'd3:    ser_data = shadow[31:24];
         3'd4:    ser_data = shadow[23:16];
         3'd5:    ser_data = shadow[15:8];
         3'd6:    ser_data = shadow[7:0];
`ifdef BLE_TELEMETRY_CHECKSUM_EN
         3'd7:    ser_data = csum;
`endif
         default: ser_data = BLE_SYNC_BYTE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fstate <= FRM_IDLE;
         idx    <= '0;
         shadow <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
`ifdef BLE_TELEMETRY_CHECKSUM_EN
         csum   <= '0;
`endif
      end else begin
         done <= 1'b0;

`ifdef BLE_TELEMETRY_CHECKSUM_EN
         // Payload bytes are summed as they are handed over, so the sum is
         // complete long before the checksum slot is loaded.
         if (ser_load && (nxt_idx != 3'd0) && (nxt_idx != 3'd7))
            csum <= csum + ser_data;
`endif

         case (fstate)
            FRM_IDLE: begin
               if (accept) begin
                  shadow <= {ble_sext16(roll), ble_sext16(pitch), ble_sext16(yaw)};
                  idx    <= '0;
                  busy   <= 1'b1;
                  fstate <= FRM_LOAD;
`ifdef BLE_TELEMETRY_CHECKSUM_EN
                  csum   <= '0;
`endif
               end
            end

            FRM_LOAD: begin
               fstate <= FRM_WAIT;
            end

            FRM_WAIT: begin
               if (ser_byte_done) begin
                  if (idx == LAST_IDX) begin
                     fstate <= FRM_IDLE;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                  end else begin
                     idx    <= idx + 3'd1;
                     fstate <= FRM_LOAD;
                  end
               end
            end

            default: begin
               fstate <= FRM_IDLE;
               busy   <= 1'b0;
            end
         endcase
      end
   end

   uart_tx_byte #(
      .DIV (DIV)
   ) u_ser (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (ser_load),
      .data      (ser_data),
      .tx        (tx),
      .ready     (ser_ready),
      .byte_done (ser_byte_done)
   );

endmodule

// File: tb/tb_ble_telemetry_tx.sv
// Directed bench for ble_telemetry_tx, run at CLK_HZ=100, BAUD=9 so the
// bit period is the truncated value 11 clocks.
module tb_ble_telemetry_tx;

   localparam int DIV = 11;
`ifdef BLE_TELEMETRY_CHECKSUM_EN
   localparam int NB = 8;
`else
   localparam int NB = 7;
`endif
   localparam int NBITS = NB * 10;
   localparam int FLEN  = NBITS * DIV;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              send = 1'b0;
   logic signed [8:0] roll = '0;
   logic signed [8:0] pitch = '0;
   logic signed [8:0] yaw = '0;
   logic              busy;
   logic              done;
   logic              tx;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_a [8];
   logic [7:0] exp_b [8];

   logic       cap_mid    [80];
   logic       cap_stable [80];
   logic [7:0] cap_byte   [8];
   int         cap_busy_bad;
   logic       end_done, end_busy, end_tx;

   ble_telemetry_tx #(
      .CLK_HZ (100),
      .BAUD   (9)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .send    (send),
      .roll    (roll),
      .pitch   (pitch),
      .yaw     (yaw),
      .busy    (busy),
      .done    (done),
      .tx      (tx)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   // Request a frame; the following posedge is the accept edge.
   task automatic pulse_send(input logic signed [8:0] r, input logic signed [8:0] p,
                             input logic signed [8:0] y);
      roll  = r;
      pitch = p;
      yaw   = y;
      send  = 1'b1;
      @(posedge clock);
      #1 send = 1'b0;
   endtask

   // Record tx/busy/done for one frame starting just after the accept edge.
   // At cycle poke_at the angles are changed and send is pulsed (-1: never).
   task automatic capture_frame(input int poke_at);
      int   b;
      logic first_val;
      first_val    = 1'b1;
      cap_busy_bad = 0;
      for (int i = 0; i < 80; i++) begin
         cap_stable[i] = 1'b1;
         cap_mid[i]    = 1'bx;
      end
      for (int c = 0; c < FLEN; c++) begin
         @(negedge clock);
         b = c / DIV;
         if (c % DIV == 0) first_val = tx;
         else if (tx !== first_val) cap_stable[b] = 1'b0;
         if (c % DIV == DIV / 2) cap_mid[b] = tx;
         if (busy !== 1'b1 || done !== 1'b0) cap_busy_bad++;
         if (c == poke_at) begin
            roll  = 9'sd77;
            pitch = -9'sd3;
            yaw   = 9'sd200;
            send  = 1'b1;
         end
         if (c == poke_at + 1) send = 1'b0;
      end
      @(negedge clock);
      end_done = done;
      end_busy = busy;
      end_tx   = tx;
      for (int k = 0; k < NB; k++)
         for (int j = 0; j < 8; j++)
            cap_byte[k][j] = cap_mid[k * 10 + 1 + j];
   endtask

   task automatic test_reset;
      int bad;
      @(negedge clock);
      @(negedge clock);
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      reset_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clock);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL idle_10k: %0d bad cycles, expected 0", bad); end
   endtask

   task automatic test_frame_bytes;
      pulse_send(-9'sd1, 9'sd90, -9'sd180);
      capture_frame(-1);
      for (int k = 0; k < NB; k++) begin
         n_checks++;
         if (cap_byte[k] !== exp_a[k]) begin
            n_fail++;
            $display("FAIL frame_byte[%0d]: got %h expected %h", k, cap_byte[k], exp_a[k]);
         end
      end
      n_checks++;
      if (cap_busy_bad != 0) begin n_fail++; $display("FAIL frame_busy: %0d bad cycles, expected 0", cap_busy_bad); end
      n_checks++;
      if (end_done !== 1'b1) begin n_fail++; $display("FAIL frame_done_at_len: got %b expected 1", end_done); end
      n_checks++;
      if (end_busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_end: got %b expected 0", end_busy); end
      n_checks++;
      if (end_tx !== 1'b1) begin n_fail++; $display("FAIL frame_tx_end: got %b expected 1", end_tx); end
      @(negedge clock);
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b expected 0", done); end
   endtask

   task automatic test_bit_timing;
      int   wrong;
      int   unstable;
      logic eb;
      pulse_send(-9'sd1, 9'sd90, -9'sd180);
      capture_frame(-1);
      for (int k = 0; k < NB; k++) begin
         n_checks++;
         if (cap_mid[k * 10] !== 1'b0) begin
            n_fail++; $display("FAIL start_bit[%0d]: got %b expected 0", k, cap_mid[k * 10]);
         end
         n_checks++;
         if (cap_mid[k * 10 + 9] !== 1'b1) begin
            n_fail++; $display("FAIL stop_bit[%0d]: got %b expected 1", k, cap_mid[k * 10 + 9]);
         end
      end
      wrong    = 0;
      unstable = 0;
      for (int b = 0; b < NBITS; b++) begin
         if (b % 10 == 0) eb = 1'b0;
         else if (b % 10 == 9) eb = 1'b1;
         else eb = exp_a[b / 10][b % 10 - 1];
         if (cap_mid[b] !== eb) wrong++;
         if (cap_stable[b] !== 1'b1) unstable++;
      end
      n_checks++;
      if (wrong != 0) begin n_fail++; $display("FAIL bit_values: %0d wrong bits, expected 0", wrong); end
      n_checks++;
      if (unstable != 0) begin n_fail++; $display("FAIL bit_period: %0d bits not %0d cycles, expected 0", unstable, DIV); end
      @(negedge clock);
   endtask

   task automatic test_isolation;
      int bad;
      pulse_send(-9'sd1, 9'sd90, -9'sd180);
      roll  = 9'sd100;
      pitch = -9'sd50;
      yaw   = 9'sd7;
      capture_frame(380);
      for (int k = 0; k < NB; k++) begin
         n_checks++;
         if (cap_byte[k] !== exp_a[k]) begin
            n_fail++;
            $display("FAIL isolation_byte[%0d]: got %h expected %h", k, cap_byte[k], exp_a[k]);
         end
      end
      n_checks++;
      if (cap_busy_bad != 0) begin n_fail++; $display("FAIL isolation_busy: %0d bad cycles, expected 0", cap_busy_bad); end
      n_checks++;
      if (end_done !== 1'b1) begin n_fail++; $display("FAIL isolation_done: got %b expected 1", end_done); end
      bad = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clock);
         if (busy !== 1'b0 || tx !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL no_second_frame: %0d bad cycles, expected 0", bad); end
   endtask

   task automatic test_back_to_back;
      pulse_send(-9'sd1, 9'sd90, -9'sd180);
      capture_frame(-1);
      n_checks++;
      if (end_done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b expected 1", end_done); end
      // Request lands in the done cycle itself.
      pulse_send(9'sd0, 9'sd0, 9'sd255);
      capture_frame(-1);
      n_checks++;
      if (cap_busy_bad != 0) begin n_fail++; $display("FAIL b2b_busy: %0d bad cycles, expected 0", cap_busy_bad); end
      n_checks++;
      if (cap_mid[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_start: got %b expected 0", cap_mid[0]); end
      for (int k = 0; k < NB; k++) begin
         n_checks++;
         if (cap_byte[k] !== exp_b[k]) begin
            n_fail++;
            $display("FAIL b2b_byte[%0d]: got %h expected %h", k, cap_byte[k], exp_b[k]);
         end
      end
      n_checks++;
      if (end_done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b expected 1", end_done); end
      @(negedge clock);
   endtask

   task automatic test_reset_mid;
      int bad;
      pulse_send(-9'sd1, 9'sd90, -9'sd180);
      // Cycle 335 lies inside the start bit of byte 3.
      for (int c = 0; c <= 335; c++) @(negedge clock);
      n_checks++;
      if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_pre_reset_tx: got %b expected 0", tx); end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL mid_reset_tx: got %b expected 1", tx); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         if (busy !== 1'b0 || tx !== 1'b1 || done !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL mid_no_resume: %0d bad cycles, expected 0", bad); end
      pulse_send(9'sd0, 9'sd0, 9'sd255);
      capture_frame(-1);
      for (int k = 0; k < NB; k++) begin
         n_checks++;
         if (cap_byte[k] !== exp_b[k]) begin
            n_fail++;
            $display("FAIL mid_clean_byte[%0d]: got %h expected %h", k, cap_byte[k], exp_b[k]);
         end
      end
      n_checks++;
      if (cap_busy_bad != 0) begin n_fail++; $display("FAIL mid_clean_busy: %0d bad cycles, expected 0", cap_busy_bad); end
      n_checks++;
      if (end_done !== 1'b1) begin n_fail++; $display("FAIL mid_clean_done: got %b expected 1", end_done); end
   endtask

   initial begin
      // roll=-1 -> FFFF, pitch=90 -> 005A, yaw=-180 -> FF4C, sum 0x3A3 -> A3
      exp_a = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h5A, 8'hFF, 8'h4C, 8'hA3};
      // roll=0, pitch=0, yaw=255 -> 00FF, sum FF
      exp_b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
      test_reset();
      test_frame_bytes();
      test_bit_timing();
      test_isolation();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
